round_robin_dispatcher: RTL and testbench

Routes a single valid/ready input stream to one of `NumDst` destinations in rotating order. It is the 1-to-N counterpart of the round-robin arbiter:

- The arbiter merges many requesters onto one resource.
- This block spreads one producer's items across many consumers, for example worker lanes or bank queues.

Destinations can be disabled at run time and are skipped. A one-entry registered output stage gives a fixed 1-cycle latency and full throughput when the selected destination is ready.

---
 rtl/round_robin_dispatcher.sv | 83 ++++++++
 tb/tb_round_robin_dispatcher.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/round_robin_dispatcher.sv
// round_robin_dispatcher
// Spreads one valid/ready input stream across NumDst destinations in rotating
// order, skipping destinations whose enable bit is low. A one-entry registered
// output stage gives a fixed 1-cycle latency and full throughput.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The input side may not depend on ready_o to drive valid_i. Each
// destination k sees valid_o[k] and answers with ready_i[k]. Once an item is
// presented, its payload and target stay put until that destination takes it.
module round_robin_dispatcher #(
    parameter int Clog2NumDst = 2,
    parameter int NumDst      = 2 ** Clog2NumDst,
    parameter int DataWidth   = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic [NumDst-1:0]    en_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic [NumDst-1:0]    valid_o,
    input  logic [NumDst-1:0]    ready_i
);

    logic                   full_q;
    logic [DataWidth-1:0]   data_q;
    logic [NumDst-1:0]      target_q;
    logic [Clog2NumDst-1:0] ptr_q;

    logic [Clog2NumDst-1:0] sel;
    logic [NumDst-1:0]      sel_onehot;
    logic                   none_en;
    logic                   out_fire;
    logic                   in_fire;

    // Pick the first enabled destination at or after ptr, cyclically. Offsets
    // are scanned from the far end down so the nearest enabled one wins. The
    // index addition wraps for free because NumDst is a power of two.
    always_comb begin
        logic [Clog2NumDst-1:0] idx;
        sel = ptr_q;
        idx = ptr_q;
        for (int i = NumDst - 1; i >= 0; i--) begin
            idx = ptr_q + Clog2NumDst'(i);
            if (en_i[idx]) begin
                sel = idx;
            end
        end
    end

    // One-hot form of the selected destination, loaded into the target register.
    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
    end

    assign none_en  = (en_i == '0);
    assign valid_o  = full_q ? target_q : '0;
    assign data_o   = data_q;
    assign out_fire = full_q & (|(target_q & ready_i));
    assign ready_o  = !none_en & (!full_q | out_fire);
    assign in_fire  = valid_i & ready_o;

    // Output stage: load on accept (also replacing a draining item), empty on
    // drain. The rotation pointer only moves when an item is accepted.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            full_q   <= 1'b0;
            data_q   <= '0;
            target_q <= '0;
            ptr_q    <= '0;
        end else if (in_fire) begin
            full_q   <= 1'b1;
            data_q   <= data_i;
            target_q <= sel_onehot;
            ptr_q    <= sel + 1'b1;
        end else if (out_fire) begin
            full_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_robin_dispatcher.sv
// Directed testbench for round_robin_dispatcher (4 destinations, 8-bit data).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_round_robin_dispatcher;

    logic       clk_i;
    logic       arst_i;
    logic [3:0] en_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic [3:0] valid_o;
    logic [3:0] ready_i;

    int checks;
    int errors;

    round_robin_dispatcher #(
        .Clog2NumDst(2),
        .DataWidth  (8)
    ) dut (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (en_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .valid_o(valid_o),
        .ready_i(ready_i)
    );

    // Clock and watchdog
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Pulse reset for one edge with all destinations enabled; check idle outputs
    // both during and after the pulse.
    task automatic do_reset(input string tag);
        valid_i = 1'b0;
        en_i    = 4'hF;
        arst_i  = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 32'(valid_o), 32'h0);
        check({tag, "_rst_data"},  32'(data_o),  32'h0);
        check({tag, "_rst_ready"}, 32'(ready_o), 32'h1);
        step();
        arst_i = 1'b0;
        #1;
        check({tag, "_post_valid"}, 32'(valid_o), 32'h0);
        check({tag, "_post_data"},  32'(data_o),  32'h0);
        check({tag, "_post_ready"}, 32'(ready_o), 32'h1);
    endtask

    // Offer one item, expect it accepted on the next edge and presented to exp_t.
    task automatic send(input string tag, input logic [7:0] d, input logic [3:0] exp_t);
        valid_i = 1'b1;
        data_i  = d;
        #1;
        check({tag, "_ready"}, 32'(ready_o), 32'h1);
        step();
        valid_i = 1'b0;
        check({tag, "_valid"}, 32'(valid_o), 32'(exp_t));
        check({tag, "_data"},  32'(data_o),  32'(d));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        arst_i  = 1'b1;
        en_i    = 4'hF;
        data_i  = 8'h00;
        valid_i = 1'b0;
        ready_i = 4'h0;
        #2;
        check("init_valid", 32'(valid_o), 32'h0);
        check("init_data",  32'(data_o),  32'h0);
        check("init_ready", 32'(ready_o), 32'h1);
        step();
        arst_i = 1'b0;
        #1;

        // 1. Reset discards a held item
        ready_i = 4'h0;
        send("t1_aa", 8'hAA, 4'b0001);
        #1;
        check("t1_held_ready", 32'(ready_o), 32'h0);
        do_reset("t1");
        ready_i = 4'hF;
        send("t1_next", 8'h55, 4'b0001);

        // 2. Full rotation, back-to-back
        do_reset("t2");
        ready_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            send("t2_item", 8'(8'h10 + i), 4'(4'b0001 << (i % 4)));
        end
        step();
        check("t2_empty", 32'(valid_o), 32'h0);

        // 3. Skip disabled destinations, then a single enabled one
        do_reset("t3");
        en_i    = 4'b1010;
        ready_i = 4'hF;
        send("t3_a", 8'h20, 4'b0010);
        send("t3_b", 8'h21, 4'b1000);
        send("t3_c", 8'h22, 4'b0010);
        send("t3_d", 8'h23, 4'b1000);
        en_i = 4'b0100;
        send("t3_e", 8'h24, 4'b0100);
        send("t3_f", 8'h25, 4'b0100);

        // 4. Backpressure on destination 2; other ready bits must be ignored
        do_reset("t4");
        ready_i = 4'hF;
        send("t4_f0", 8'h01, 4'b0001);
        send("t4_f1", 8'h02, 4'b0010);
        ready_i = 4'b1011;
        send("t4_30", 8'h30, 4'b0100);
        valid_i = 1'b1;
        data_i  = 8'h31;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_hold_valid", 32'(valid_o), 32'h4);
            check("t4_hold_data",  32'(data_o),  32'h30);
            check("t4_hold_ready", 32'(ready_o), 32'h0);
            step();
        end
        ready_i = 4'hF;
        #1;
        check("t4_last_valid", 32'(valid_o), 32'h4);
        check("t4_last_data",  32'(data_o),  32'h30);
        check("t4_drain_ready", 32'(ready_o), 32'h1);
        step();
        valid_i = 1'b0;
        check("t4_31_valid", 32'(valid_o), 32'h8);
        check("t4_31_data",  32'(data_o),  32'h31);

        // 5. No destinations enabled: held item drains, nothing accepted
        do_reset("t5");
        ready_i = 4'hF;
        send("t5_40", 8'h40, 4'b0001);
        ready_i = 4'b0001;
        send("t5_41", 8'h41, 4'b0010);
        ready_i = 4'h0;
        en_i    = 4'h0;
        valid_i = 1'b1;
        data_i  = 8'h42;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t5_off_ready", 32'(ready_o), 32'h0);
            check("t5_off_valid", 32'(valid_o), 32'h2);
            check("t5_off_data",  32'(data_o),  32'h41);
            step();
        end
        ready_i = 4'b0010;
        #1;
        check("t5_drain_ready", 32'(ready_o), 32'h0);
        step();
        check("t5_drained_valid", 32'(valid_o), 32'h0);
        check("t5_drained_ready", 32'(ready_o), 32'h0);
        step();
        check("t5_idle_valid", 32'(valid_o), 32'h0);
        en_i = 4'b0001;
        send("t5_42", 8'h42, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
